circular_shifter: RTL and testbench
===================================

Name: circular_shifter

Overview:
- Free-running circular (ring) shift register: a WIDTH-bit pattern rotates by one position on every clock edge.
- Loaded with a fixed seed on reset. No data inputs.
- Used as a ring counter / one-hot sequencer driving phase-select or strobe logic elsewhere in the design.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..64.
- INIT, 1 (WIDTH-bit value, LSB set), seed loaded on reset; any WIDTH-bit value is legal, including zero.
- DIR, 0, rotation direction: 0 = rotate left (toward MSB), 1 = rotate right (toward LSB).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  reset, asynchronous, active-low; asserting it forces out to INIT immediately, independent of clk.
- out  output  WIDTH  current register contents, driven directly from flops (no combinational path).

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset:
  - While n_rst = 0, out = INIT[WIDTH-1:0] and holds, regardless of clk.
  - Assertion takes effect without waiting for a clock edge.
- Deassertion:
  - The first rising edge of clk with n_rst = 1 performs the first rotation.
  - There is no extra idle cycle after reset release.
- Rotation, every rising clk edge with n_rst = 1:
  - DIR = 0: out <= {out[WIDTH-2:0], out[WIDTH-1]}. The MSB wraps into bit 0.
  - DIR = 1: out <= {out[0], out[WIDTH-1:1]}. The LSB wraps into bit WIDTH-1.
- Latency:
  - out reflects a rotation one clock after the edge, as a registered output.
  - The sequence is periodic with period WIDTH cycles, or a divisor of WIDTH if the pattern is self-similar.
- Bit conservation:
  - The population count of out never changes between resets.
  - INIT = 0 gives out = 0 forever.
  - INIT = all-ones gives out = all-ones forever.
- Reset mid-operation: asserting n_rst at any phase, including between clock edges, returns out to INIT. The rotation phase restarts from INIT after release.
- No enable, no load, no direction change at runtime. DIR and INIT are elaboration-time constants.
- WIDTH outside 2..64: elaboration error via a generate-time check.
- X-safety: out must never be X after the first reset assertion.
- Implementation style:
  - Must be a plain always block using nonblocking assignments.
  - Sensitivity list is posedge clk or negedge n_rst.

Test Plan:
- WIDTH=4, INIT=4'b0001, DIR=0, clk period 4 ns:
  - Hold n_rst=0 for 2 cycles -> out=0001 throughout.
  - Release -> successive edges give 0010, 0100, 1000, 0001, 0010 ...
  - Run 30 cycles -> out repeats every 4 cycles, popcount stays 1.
- Same configuration, assert n_rst low mid-cycle while out=0100 -> out becomes 0001 immediately, before the next clk edge. After release, the first edge gives 0010.
- WIDTH=4, INIT=4'b0001, DIR=1 -> after reset release: 1000, 0100, 0010, 0001, 1000 ...
- WIDTH=8, INIT=8'b0000_0011, DIR=0 -> 00000110, 00001100, ..., 11000000, 10000001, 00000011. Period 8 cycles, popcount stays 2.
- WIDTH=4, INIT=4'b0000 -> out=0000 for all cycles.
- WIDTH=4, INIT=4'b1111 -> out=1111 for all cycles.
- WIDTH=4, INIT=4'b0101 -> out alternates 1010/0101, period 2.
- Power-up with n_rst=0 from time 0 -> out=INIT before the first clk edge, with no X on out at any sampled negedge.

Source files
------------

// File: rtl/circular_shifter.sv
// circular_shifter: free-running ring shift register.
// Rotates a seeded WIDTH-bit pattern by one bit every clock.
module circular_shifter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1),
  parameter bit               DIR   = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  output logic [WIDTH-1:0] out
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("circular_shifter: WIDTH must be in 2..64");
  end

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  if (DIR == 1'b0) begin : g_left
    // MSB wraps around into bit 0
    always_comb begin
      out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
    end
  end else begin : g_right
    // LSB wraps around into the MSB
    always_comb begin
      out_d = {out_q[0], out_q[WIDTH-1:1]};
    end
  end

  // pattern register, reseeded asynchronously
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_q <= INIT;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_circular_shifter.sv
// tb_circular_shifter: six shifter configurations sharing clk/reset,
// checked against an index-arithmetic rotation model.
`timescale 1ns/100ps
module tb_circular_shifter;

  localparam int NI = 6;
  localparam int WV [NI] = '{4, 4, 8, 4, 4, 4};
  localparam logic [63:0] IV [NI] = '{
    64'h1, 64'h1, 64'h3, 64'h0, 64'hF, 64'h5};
  localparam bit DV [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  logic clk;
  logic n_rst;
  logic [3:0] o0, o1, o3, o4, o5;
  logic [7:0] o2;
  logic [63:0] obs [NI];

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  circular_shifter #(.WIDTH(4), .INIT(4'b0001), .DIR(1'b0))
    u0 (.clk(clk), .n_rst(n_rst), .out(o0));
  circular_shifter #(.WIDTH(4), .INIT(4'b0001), .DIR(1'b1))
    u1 (.clk(clk), .n_rst(n_rst), .out(o1));
  circular_shifter #(.WIDTH(8), .INIT(8'b0000_0011), .DIR(1'b0))
    u2 (.clk(clk), .n_rst(n_rst), .out(o2));
  circular_shifter #(.WIDTH(4), .INIT(4'b0000), .DIR(1'b0))
    u3 (.clk(clk), .n_rst(n_rst), .out(o3));
  circular_shifter #(.WIDTH(4), .INIT(4'b1111), .DIR(1'b0))
    u4 (.clk(clk), .n_rst(n_rst), .out(o4));
  circular_shifter #(.WIDTH(4), .INIT(4'b0101), .DIR(1'b0))
    u5 (.clk(clk), .n_rst(n_rst), .out(o5));

  assign obs[0] = 64'(o0);
  assign obs[1] = 64'(o1);
  assign obs[2] = 64'(o2);
  assign obs[3] = 64'(o3);
  assign obs[4] = 64'(o4);
  assign obs[5] = 64'(o5);

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Bit i after k rotations came from bit i-k (left) or i+k (right).
  function automatic logic [63:0] model(input int w,
                                        input logic [63:0] init,
                                        input bit dir,
                                        input int kk);
    logic [63:0] r;
    int s;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (!dir) s = ((i - kk) % w + w) % w;
      else      s = (i + kk) % w;
      r[i] = init[s];
    end
    return r;
  endfunction

  task automatic check_all(input string ph);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s u%0d k%0d", ph, i, k), obs[i],
          model(WV[i], IV[i], DV[i], k));
      chk($sformatf("%s pop u%0d", ph, i),
          64'($countones(obs[i])), 64'($countones(IV[i])));
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
    check_all("run");
  endtask

  task automatic mid_reset();
    @(posedge clk);
    k++;
    #1;
    check_all("pre");
    n_rst = 1'b0;
    k = 0;
    #0.5;
    check_all("async");
    @(negedge clk);
    check_all("hold");
    @(negedge clk);
    check_all("hold");
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b1;
    #0.2;
    n_rst = 1'b0;
    #0.8;
    k = 0;
    check_all("pwrup");
    @(negedge clk);
    check_all("rst");
    @(negedge clk);
    check_all("rst");
    #1;
    n_rst = 1'b1;
    step();
    step();
    mid_reset();
    for (int e = 0; e < 5; e++) begin
      int n;
      n = $urandom_range(3, 20);
      for (int c = 0; c < n; c++) step();
      mid_reset();
    end
    for (int c = 0; c < 30; c++) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
